// File: rtl/serial_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package serial_pkg;

  localparam int unsigned BUS_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BAUD_W = 16;

  localparam logic [BUS_W-1:0] SERIAL_DATA_ADDR = 16'hBF00;
  localparam logic [BUS_W-1:0] SERIAL_STAT_ADDR = 16'hBF01;

  // Status word bit positions
  localparam int unsigned READY    = 0;
  localparam int unsigned RX_READY = 1;
  localparam int unsigned IDLE     = 2;
  localparam int unsigned OVERRUN  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/serial_tx_if.sv
// Data-memory bus slice seen by the serial port.
interface serial_tx_if;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output mem_we, output mem_re, output addr, output wdata, input rdata);
  modport slave  (input mem_we, input mem_re, input addr, input wdata, output rdata);
endinterface

// File: rtl/serial_fifo.sv
// Byte FIFO with first-word fall-through read port; push when full and pop when empty are ignored.
module serial_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == CNT_W'(0));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/serial_tx.sv
// UART 8N1 transmitter on the data-memory bus: data register, status word, byte FIFO and TX FSM.
module serial_tx
  import serial_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  serial_tx_if.slave  bus,
  output logic        txd,
  output logic        tx_idle
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e          state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               idle_q, idle_d;
  logic               overrun_q, overrun_d;

  logic               wr_data_c, rd_stat_c, push, pop, baud_last_c;
  logic               fifo_full, fifo_empty;
  logic [BYTE_W-1:0]  fifo_dout;
  logic [CNT_W-1:0]   fifo_count;
  logic               unused_wdata_hi;

  assign wr_data_c       = bus.mem_we && (bus.addr == SERIAL_DATA_ADDR);
  assign rd_stat_c       = bus.mem_re && (bus.addr == SERIAL_STAT_ADDR);
  assign push            = wr_data_c && !fifo_full;
  assign baud_last_c     = (baud_q == BAUD_W'(CLK_DIV - 1));
  assign unused_wdata_hi = ^bus.wdata[15:8];
  assign txd             = txd_q;
  assign tx_idle         = idle_q;

  serial_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Status mux; any other read returns zero
  always_comb begin
    bus.rdata = '0;
    if (rd_stat_c) begin
      bus.rdata[READY]    = !fifo_full;
      bus.rdata[RX_READY] = 1'b0;
      bus.rdata[IDLE]     = idle_q;
      bus.rdata[OVERRUN]  = overrun_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      idle_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      idle_q    <= idle_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state; line level and idle flag are computed from the next state so they register cleanly
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    txd_d     = 1'b1;
    idle_d    = 1'b0;
    overrun_d = overrun_q;

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last_c) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[BYTE_W-1:1]};
          if (bit_q == 3'd7) state_d = ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_last_c) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_d[0];
      default:  txd_d = 1'b1;
    endcase

    // pop never coincides with an empty FIFO, so empty-after-edge needs only these two cases
    idle_d = (state_d == ST_IDLE) &&
             (((fifo_count == CNT_W'(0)) && !push) ||
              ((fifo_count == CNT_W'(1)) && pop && !push));

    if (rd_stat_c)                  overrun_d = 1'b0;
    else if (wr_data_c && fifo_full) overrun_d = 1'b1;
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx with CLK_DIV=4, FIFO_DEPTH=4; a line monitor decodes frames off txd.
module tb_serial_tx;

  localparam int unsigned DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd, tx_idle;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [7:0] rx_q [$];
  int         rx_t [$];

  serial_tx_if bus_if ();

  serial_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .txd     (txd),
    .tx_idle (tx_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_txd;
    logic        exp_idle;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame decoder: samples at negedges, mid-bit, restarts on reset
  initial begin : monitor
    int ph;
    int st;
    logic [7:0] sh;
    ph = -1;
    st = 0;
    sh = '0;
    forever begin
      @(negedge clk);
      if (!rst) ph = -1;
      else if (ph < 0) begin
        if (txd === 1'b0) begin
          ph = 0;
          st = cyc;
        end
      end else begin
        ph++;
        if (ph == 2) check("mon_start_bit", 16'(txd), 16'h0);
        if (ph >= 6 && ph <= 34 && ((ph - 6) % 4) == 0) sh[(ph - 6) / 4] = txd;
        if (ph == 38) begin
          check("mon_stop_bit", 16'(txd), 16'h1);
          rx_q.push_back(sh);
          rx_t.push_back(st);
          ph = -1;
        end
      end
    end
  end

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    bus_if.mem_we = 1'b1;
    bus_if.addr   = a;
    bus_if.wdata  = d;
    @(posedge clk);
    @(negedge clk);
    bus_if.mem_we = 1'b0;
  endtask

  task automatic read_status(output logic [15:0] v);
    bus_if.mem_re = 1'b1;
    bus_if.addr   = 16'hBF01;
    #1 v = bus_if.rdata;
    @(posedge clk);
    @(negedge clk);
    bus_if.mem_re = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!tx_idle && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 16'(tx_idle), 16'h1);
  endtask

  task automatic wait_frames(input int nfr, input int bound);
    int n = 0;
    while (rx_q.size() < nfr && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_frames", 16'(rx_q.size()), 16'(nfr));
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    logic [7:0] t;
    t = b;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return t[k-1];
  endfunction

  // Precondition: called at the negedge before the edge on which START begins
  task automatic expect_frame(input logic [7:0] b);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < int'(DIV); c++) begin
        @(posedge clk);
        @(negedge clk);
        check($sformatf("frame_%h_bit%0d", b, k), 16'(txd), 16'(frame_bit(b, k)));
      end
    end
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp [5]);
    for (int i = 0; i < 5; i++) begin
      if (i < rx_q.size()) check($sformatf("%s_byte%0d", name, i), 16'(rx_q[i]), 16'(exp[i]));
      if (i > 0 && i < rx_t.size())
        check($sformatf("%s_gap%0d", name, i), 16'(rx_t[i] - rx_t[i-1]), 16'(10 * DIV));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vec_t       vecs [8];
    logic [15:0] s;
    logic [7:0] exp5 [5];
    int         low_cnt;

    bus_if.mem_we = 1'b0;
    bus_if.mem_re = 1'b0;
    bus_if.addr   = 16'h0000;
    bus_if.wdata  = 16'h0000;

    vecs[0] = '{1'b0, 1'b1, 16'hBF01, 16'h0000, 16'h0005, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 16'hBF00, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'hBF01, 16'h0077, 16'h0000, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'h1234, 16'h0088, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 16'hBF01, 16'h0099, 16'h0005, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 16'hBF01, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 16'hBF01, 16'h0000, 16'h0005, 1'b1, 1'b1};

    // Reset state, observed while reset is held
    #3 rst = 1'b0;
    bus_if.mem_re = 1'b1;
    bus_if.addr   = 16'hBF01;
    #1;
    check("rst_txd", 16'(txd), 16'h1);
    check("rst_idle", 16'(tx_idle), 16'h1);
    check("rst_status", bus_if.rdata, 16'h0005);
    bus_if.mem_re = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Status and decode table: only the status address reads back, nothing is queued
    for (int i = 0; i < 8; i++) begin
      bus_if.mem_we = vecs[i].we;
      bus_if.mem_re = vecs[i].re;
      bus_if.addr   = vecs[i].addr;
      bus_if.wdata  = vecs[i].wdata;
      #1;
      check($sformatf("vec%0d_rdata", i), bus_if.rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_txd", i), 16'(txd), 16'(vecs[i].exp_txd));
      check($sformatf("vec%0d_idle", i), 16'(tx_idle), 16'(vecs[i].exp_idle));
      @(posedge clk);
      @(negedge clk);
    end
    bus_if.mem_we = 1'b0;
    bus_if.mem_re = 1'b0;
    repeat (8) @(negedge clk);
    check("decode_txd_quiet", 16'(txd), 16'h1);
    check("decode_rx_none", 16'(rx_q.size()), 16'h0);
    read_status(s);
    check("decode_status", s, 16'h0005);

    // Single frame 0x55 with exact bit timing
    bus_write(16'hBF00, 16'h0055);
    check("f55_idle_low", 16'(tx_idle), 16'h0);
    check("f55_txd_pre", 16'(txd), 16'h1);
    expect_frame(8'h55);
    check("f55_idle_at40", 16'(tx_idle), 16'h0);
    @(posedge clk);
    @(negedge clk);
    check("f55_idle_at41", 16'(tx_idle), 16'h1);
    check("f55_rx_count", 16'(rx_q.size()), 16'h1);
    if (rx_q.size() > 0) check("f55_rx_byte", 16'(rx_q[0]), 16'h0055);
    rx_q.delete();
    rx_t.delete();

    // Burst of six: five accepted, sixth overruns
    for (int i = 1; i <= 6; i++) bus_write(16'hBF00, 16'(i));
    read_status(s);
    check("ovr_status_set", s, 16'h0008);
    read_status(s);
    check("ovr_status_clr", s, 16'h0000);
    wait_frames(5, 260);
    for (int i = 0; i < 5; i++) exp5[i] = 8'(i + 1);
    check_rx("burst", exp5);
    wait_idle(100);
    repeat (50) @(negedge clk);
    check("burst_no_sixth", 16'(rx_q.size()), 16'h5);
    read_status(s);
    check("burst_status_end", s, 16'h0005);
    rx_q.delete();
    rx_t.delete();

    // Push on the last STOP cycle with three bytes queued
    bus_write(16'hBF00, 16'h0010);
    bus_write(16'hBF00, 16'h0020);
    bus_write(16'hBF00, 16'h0030);
    bus_write(16'hBF00, 16'h0040);
    repeat (37) @(negedge clk);
    bus_write(16'hBF00, 16'h0050);
    read_status(s);
    check("stopedge_status", s, 16'h0001);
    wait_frames(5, 300);
    exp5[0] = 8'h10; exp5[1] = 8'h20; exp5[2] = 8'h30; exp5[3] = 8'h40; exp5[4] = 8'h50;
    check_rx("stopedge", exp5);
    wait_idle(100);
    read_status(s);
    check("stopedge_status_end", s, 16'h0005);
    rx_q.delete();
    rx_t.delete();

    // Reset in the middle of the DATA bits of 0xA3
    bus_write(16'hBF00, 16'h00A3);
    bus_write(16'hBF00, 16'h0011);
    bus_write(16'hBF00, 16'h0022);
    repeat (18) @(negedge clk);
    check("midrst_txd_before", 16'(txd), 16'h0);
    rst = 1'b0;
    #1;
    check("midrst_txd_async", 16'(txd), 16'h1);
    check("midrst_idle_async", 16'(tx_idle), 16'h1);
    bus_if.mem_re = 1'b1;
    bus_if.addr   = 16'hBF01;
    #1;
    check("midrst_status_in_rst", bus_if.rdata, 16'h0005);
    bus_if.mem_re = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    check("midrst_line_quiet", 16'(low_cnt), 16'h0);
    check("midrst_rx_none", 16'(rx_q.size()), 16'h0);
    read_status(s);
    check("midrst_status_after", s, 16'h0005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
